// File: rtl/mlp_pkg.sv
// Shared definitions for the MLP streaming inference core: FSM encoding,
// accumulator saturation bounds and ReLU clamp limits.
package mlp_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_L1,
    S_L1_DRAIN,
    S_RELU,
    S_L2,
    S_L2_DRAIN,
    S_ARGMAX,
    S_OUT
  } mlp_state_t;

  localparam longint RELU_MIN = 0;

  function automatic longint relu_max(input int dw);
    return (64'sd1 <<< (dw - 1)) - 64'sd1;
  endfunction

  function automatic longint sat_max(input int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic longint sat_min(input int w);
    return -(64'sd1 <<< (w - 1));
  endfunction

endpackage

// File: rtl/mlp_mac_lane.sv
// One signed multiply-accumulate lane with bias preload.
// Define MLP_ACC_SAT_EN to saturate every accumulator update instead of wrapping.
module mlp_mac_lane
  import mlp_pkg::*;
#(
  parameter int DW    = 8,
  parameter int ACC_W = 20
) (
  input  logic                    clk,
  input  logic                    i_load,
  input  logic                    i_en,
  input  logic signed [DW-1:0]    i_bias,
  input  logic signed [DW-1:0]    i_a,
  input  logic signed [DW-1:0]    i_b,
  output logic signed [ACC_W-1:0] o_acc
);

  logic signed [2*DW-1:0]  w_prod;
  logic signed [ACC_W-1:0] w_prod_ext;
  logic signed [ACC_W-1:0] w_bias_ext;
  logic signed [ACC_W-1:0] w_mac_val;
  logic signed [ACC_W-1:0] w_load_val;
  logic signed [ACC_W-1:0] r_acc;

  assign w_prod     = i_a * i_b;
  assign w_prod_ext = ACC_W'(w_prod);
  assign w_bias_ext = ACC_W'(i_bias);

`ifdef MLP_ACC_SAT_EN
  localparam logic signed [ACC_W:0] SAT_HI = (ACC_W+1)'(sat_max(ACC_W));
  localparam logic signed [ACC_W:0] SAT_LO = (ACC_W+1)'(sat_min(ACC_W));

  function automatic logic signed [ACC_W-1:0] sat_acc(input logic signed [ACC_W:0] v);
    if (v > SAT_HI) return SAT_HI[ACC_W-1:0];
    if (v < SAT_LO) return SAT_LO[ACC_W-1:0];
    return v[ACC_W-1:0];
  endfunction

  // One guard bit is enough: a single update can overshoot the range by at most 2x.
  logic signed [ACC_W:0] w_sum;
  assign w_sum      = (ACC_W+1)'(r_acc) + (ACC_W+1)'(w_prod_ext);
  assign w_mac_val  = sat_acc(w_sum);
  assign w_load_val = sat_acc((ACC_W+1)'(w_bias_ext));
`else
  assign w_mac_val  = r_acc + w_prod_ext;
  assign w_load_val = w_bias_ext;
`endif

  always_ff @(posedge clk) begin
    if (i_load) begin
      r_acc <= w_load_val;
    end else if (i_en) begin
      r_acc <= w_mac_val;
    end
  end

  assign o_acc = r_acc;

endmodule

// File: rtl/mlp_stream_core.sv
// Two-layer streaming MLP classifier: pixels stream straight into parallel layer-1 MACs,
// then a serial sweep over hidden units feeds layer 2. Optional macro: MLP_ACC_SAT_EN.
module mlp_stream_core
  import mlp_pkg::*;
#(
  parameter int IN_SIZE  = 784,
  parameter int HID_SIZE = 32,
  parameter int OUT_SIZE = 10,
  parameter int DW       = 8,
  parameter int ACC_W    = 20,
  parameter int RQ_SHIFT = 0,
  parameter int IDX_W    = 10,
  parameter int CLS_W    = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     pix_valid,
  output logic                     pix_ready,
  input  logic signed [DW-1:0]     pix_data,
  output logic                     wt_rd_en,
  output logic                     wt_layer,
  output logic [IDX_W-1:0]         wt_row,
  input  logic [HID_SIZE*DW-1:0]   wt_data,
  input  logic [HID_SIZE*DW-1:0]   bias_l1,
  input  logic [OUT_SIZE*DW-1:0]   bias_l2,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [CLS_W-1:0]         res_class,
  output logic signed [ACC_W-1:0]  res_score,
  output logic                     busy
);

  localparam int HID_IW = (HID_SIZE > 1) ? $clog2(HID_SIZE) : 1;
  localparam logic [IDX_W-1:0] LAST_PIX = IDX_W'(IN_SIZE - 1);
  localparam logic [IDX_W-1:0] LAST_HID = IDX_W'(HID_SIZE - 1);
  localparam logic signed [ACC_W-1:0] RELU_HI = ACC_W'(relu_max(DW));
  localparam logic signed [ACC_W-1:0] RELU_LO = ACC_W'(RELU_MIN);

  mlp_state_t              r_state;
  logic [IDX_W-1:0]        r_pix_cnt;
  logic [IDX_W-1:0]        r_hid_cnt;
  logic                    r_pvld_p0;
  logic                    r_l2vld_p0;
  logic signed [DW-1:0]    r_pix_p0;
  logic [HID_IW-1:0]       r_hid_p0;
  logic signed [DW-1:0]    r_act [HID_SIZE];
  logic                    r_res_valid;
  logic [CLS_W-1:0]        r_res_class;
  logic signed [ACC_W-1:0] r_res_score;

  logic signed [ACC_W-1:0] w_acc1 [HID_SIZE];
  logic signed [ACC_W-1:0] w_acc2 [OUT_SIZE];
  logic                    w_pix_acc;
  logic                    w_load;
  logic signed [DW-1:0]    w_act_sel;
  logic [CLS_W-1:0]        w_best_idx;
  logic signed [ACC_W-1:0] w_best_val;

  function automatic logic signed [DW-1:0] relu_q(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W-1:0] s;
    s = a >>> RQ_SHIFT;
    if (s < RELU_LO) return '0;
    if (s > RELU_HI) return RELU_HI[DW-1:0];
    return s[DW-1:0];
  endfunction

  assign pix_ready = !rst && (r_state == S_IDLE || r_state == S_L1);
  assign w_pix_acc = pix_valid && pix_ready;
  assign wt_rd_en  = w_pix_acc || (!rst && r_state == S_L2);
  assign wt_layer  = (r_state == S_L2);
  assign wt_row    = (r_state == S_L2) ? r_hid_cnt : r_pix_cnt;
  assign busy      = !rst && (r_state != S_IDLE);
  assign res_valid = !rst && r_res_valid;
  assign res_class = r_res_class;
  assign res_score = r_res_score;
  assign w_load    = (r_state == S_IDLE);
  assign w_act_sel = r_act[r_hid_p0];

  // p0: pixel / hidden index aligned with the weight row returned one cycle later
  always_ff @(posedge clk) begin
    r_pix_p0 <= pix_data;
    r_hid_p0 <= r_hid_cnt[HID_IW-1:0];
  end

  for (genvar k = 0; k < HID_SIZE; k++) begin : g_l1
    mlp_mac_lane #(.DW(DW), .ACC_W(ACC_W)) u_lane (
      .clk    (clk),
      .i_load (w_load),
      .i_en   (r_pvld_p0),
      .i_bias ($signed(bias_l1[k*DW +: DW])),
      .i_a    (r_pix_p0),
      .i_b    ($signed(wt_data[k*DW +: DW])),
      .o_acc  (w_acc1[k])
    );
  end

  for (genvar j = 0; j < OUT_SIZE; j++) begin : g_l2
    mlp_mac_lane #(.DW(DW), .ACC_W(ACC_W)) u_lane (
      .clk    (clk),
      .i_load (w_load),
      .i_en   (r_l2vld_p0),
      .i_bias ($signed(bias_l2[j*DW +: DW])),
      .i_a    (w_act_sel),
      .i_b    ($signed(wt_data[j*DW +: DW])),
      .o_acc  (w_acc2[j])
    );
  end

  // Strict greater-than keeps the lowest index on ties
  always_comb begin
    w_best_val = w_acc2[0];
    w_best_idx = '0;
    for (int j = 1; j < OUT_SIZE; j++) begin
      if (w_acc2[j] > w_best_val) begin
        w_best_val = w_acc2[j];
        w_best_idx = CLS_W'(j);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_pix_cnt   <= '0;
      r_hid_cnt   <= '0;
      r_pvld_p0   <= 1'b0;
      r_l2vld_p0  <= 1'b0;
      r_res_valid <= 1'b0;
      r_res_class <= '0;
      r_res_score <= '0;
      for (int k = 0; k < HID_SIZE; k++) r_act[k] <= '0;
    end else begin
      r_pvld_p0  <= w_pix_acc;
      r_l2vld_p0 <= (r_state == S_L2);
      case (r_state)
        S_IDLE, S_L1: begin
          if (w_pix_acc) begin
            if (r_pix_cnt == LAST_PIX) begin
              r_pix_cnt <= '0;
              r_state   <= S_L1_DRAIN;
            end else begin
              r_pix_cnt <= r_pix_cnt + IDX_W'(1);
              r_state   <= S_L1;
            end
          end
        end
        S_L1_DRAIN: r_state <= S_RELU;
        S_RELU: begin
          for (int k = 0; k < HID_SIZE; k++) r_act[k] <= relu_q(w_acc1[k]);
          r_hid_cnt <= '0;
          r_state   <= S_L2;
        end
        S_L2: begin
          r_hid_cnt <= r_hid_cnt + IDX_W'(1);
          if (r_hid_cnt == LAST_HID) r_state <= S_L2_DRAIN;
        end
        S_L2_DRAIN: r_state <= S_ARGMAX;
        S_ARGMAX: begin
          r_res_class <= w_best_idx;
          r_res_score <= w_best_val;
          r_res_valid <= 1'b1;
          r_state     <= S_OUT;
        end
        S_OUT: begin
          if (res_ready) begin
            r_res_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
